// File: rtl/fb_writer.sv
// Generic single-clock FIFO; DEPTH must be a power of two.
// Latency: pushed word visible at dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no push-through when full.
module fb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Frame-buffer writer: drains buffered pixel requests and runs clipped block fills into frame RAM during vblank.
// Latency: request accepted at edge N is written (mem_we) after edge N+2; fills write one pixel per vblank cycle.
// Backpressure: req_ready low while the request buffer is full; fill_start only taken when idle.
module fb_writer #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 4,
    parameter int FB_SIZE    = 307200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_done,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        drop_cnt
);
    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_SIZE);

    state_t                   state;
    state_t                   state_nxt;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_dout;
    logic                     req_acc;
    logic                     req_oob;
    logic                     push;
    logic                     pop;
    logic                     fill_acc;
    logic                     fill_degen;
    logic                     fill_wr;
    logic                     fill_end;
    // One extra bit so the clip compare cannot be fooled by address wrap.
    logic [ADDR_W:0]          fill_addr;
    logic [ADDR_W-1:0]        fill_rem;
    logic [DATA_W-1:0]        fill_col;

    assign req_ready  = !fifo_full;
    assign req_acc    = req_valid && req_ready;
    assign req_oob    = ({1'b0, req_addr} >= FB_LIMIT);
    assign push       = req_acc && !req_oob;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign fill_degen = (fill_len == '0) || ({1'b0, fill_base} >= FB_LIMIT);

    fb_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({req_addr, req_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fill_acc  = 1'b0;
        fill_wr   = 1'b0;
        fill_end  = 1'b0;
        case (state)
            IDLE: begin
                // A fill wins over draining; entries pushed meanwhile wait in the buffer.
                if (fill_start) begin
                    fill_acc = 1'b1;
                    if (!fill_degen) state_nxt = FILL;
                end else if (!fifo_empty && vblank) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty || !vblank) state_nxt = IDLE;
                else                       pop = 1'b1;
            end
            FILL: begin
                if (fill_rem == '0 || fill_addr >= FB_LIMIT) begin
                    fill_end  = 1'b1;
                    state_nxt = IDLE;
                end else if (vblank) begin
                    fill_wr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_done <= 1'b0;
            drop_cnt  <= '0;
            fill_addr <= '0;
            fill_rem  <= '0;
            fill_col  <= '0;
        end else begin
            mem_we    <= pop || fill_wr;
            // Degenerate fills never enter FILL, so they report completion straight away.
            fill_done <= fill_end || (fill_acc && fill_degen);
            if (pop) begin
                mem_addr  <= fifo_dout[ADDR_W+DATA_W-1:DATA_W];
                mem_wdata <= fifo_dout[DATA_W-1:0];
            end else if (fill_wr) begin
                mem_addr  <= fill_addr[ADDR_W-1:0];
                mem_wdata <= fill_col;
                fill_addr <= fill_addr + (ADDR_W+1)'(1);
                fill_rem  <= fill_rem - ADDR_W'(1);
            end
            if (fill_acc) begin
                fill_addr <= {1'b0, fill_base};
                fill_rem  <= fill_len;
                fill_col  <= fill_color;
            end
            if (req_acc && req_oob && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: table of single requests, directed multi-cycle sequences, and randomized
// traffic compared against a write-log model built from the intended behaviour.
module tb_fb_writer;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 4;
    localparam int FB_SIZE  = 307200;
    localparam int ADDR_MAX = (1 << ADDR_W) - 1;

    logic              clk;
    logic              rst;
    logic              vblank;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_len;
    logic [DATA_W-1:0] fill_color;
    logic              fill_done;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        drop_cnt;

    fb_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(FB_SIZE), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .vblank(vblank),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_color(fill_color),
        .fill_done(fill_done), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .drop_cnt(drop_cnt)
    );

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int addr; int data; bit exp_wr; int exp_drop; } vec_t;

    wr_t  wlog[$];
    int   done_q[$];
    int   cyc = 0;
    logic last_vb = 1'b0;
    int   vb_viol = 0;
    int   total = 0;
    int   bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        last_vb <= vblank;
    end

    // Log every frame-RAM write and every fill_done, tagged with the edge that produced it.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) begin
                wlog.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
                if (!last_vb) vb_viol++;
            end
            if (fill_done) done_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = 1'b0;
        fill_start = 1'b0;
        vblank     = 1'b0;
        #1;
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_fill_done", 32'(fill_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        wlog.delete();
        done_q.delete();
        rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 1);
        @(negedge clk);
    endtask

    task automatic drive_req(input int a, input int d, output bit acc, output int acc_cyc);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        req_data  = DATA_W'(d);
        acc       = req_ready;
        acc_cyc   = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic start_fill(input int base, input int len, input int col, output int acc_cyc);
        fill_start = 1'b1;
        fill_base  = ADDR_W'(base);
        fill_len   = ADDR_W'(len);
        fill_color = DATA_W'(col);
        acc_cyc    = cyc + 1;
        @(negedge clk);
        fill_start = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        wr_t  exp_q[$];
        bit   acc;
        int   ac;
        int   f;
        int   nacc;
        int   drops;
        int   a;
        int   d;
        int   base;
        int   len;
        int   col;
        int   nwr;

        vecs[0] = '{5, 10, 1'b1, 0};
        vecs[1] = '{0, 0, 1'b1, 0};
        vecs[2] = '{FB_SIZE - 1, 15, 1'b1, 0};
        vecs[3] = '{FB_SIZE, 3, 1'b0, 1};
        vecs[4] = '{400000, 1, 1'b0, 2};
        vecs[5] = '{ADDR_MAX, 7, 1'b0, 3};
        vecs[6] = '{123456, 5, 1'b1, 3};

        rst        = 1'b1;
        vblank     = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_color = '0;
        #2;
        do_reset();

        // Single requests with vblank high: in-range ones write two edges after acceptance.
        vblank = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wlog.delete();
            drive_req(vecs[i].addr, vecs[i].data, acc, ac);
            repeat (5) @(negedge clk);
            check("tbl_accepted", 32'(acc), 1);
            check("tbl_write_count", wlog.size(), vecs[i].exp_wr ? 1 : 0);
            if (vecs[i].exp_wr && wlog.size() > 0) begin
                check("tbl_addr", wlog[0].addr, vecs[i].addr);
                check("tbl_data", wlog[0].data, vecs[i].data);
                check("tbl_latency", wlog[0].cyc, ac + 2);
            end
            check("tbl_drop_cnt", 32'(drop_cnt), vecs[i].exp_drop);
            check("tbl_busy_idle", 32'(busy), 0);
        end

        // Fill the buffer outside vblank, then drain it in one burst.
        do_reset();
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            drive_req(1000 + i, i, acc, ac);
            if (acc) nacc++;
        end
        check("full_accepted", nacc, 8);
        check("full_ready_low", 32'(req_ready), 0);
        check("full_busy", 32'(busy), 1);
        repeat (5) @(negedge clk);
        check("full_no_write", wlog.size(), 0);
        vblank = 1'b1;
        repeat (15) @(negedge clk);
        check("burst_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            check("burst_addr", wlog[i].addr, 1000 + i);
            check("burst_data", wlog[i].data, i);
            check("burst_consecutive", wlog[i].cyc, wlog[0].cyc + i);
        end
        check("burst_ready_back", 32'(req_ready), 1);

        // Fill clipped at the end of the frame buffer.
        wlog.delete();
        done_q.delete();
        start_fill(FB_SIZE - 2, 10, 3, f);
        repeat (8) @(negedge clk);
        check("clip_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("clip_addr0", wlog[0].addr, FB_SIZE - 2);
            check("clip_addr1", wlog[1].addr, FB_SIZE - 1);
            check("clip_color", wlog[1].data, 3);
            check("clip_first_cyc", wlog[0].cyc, f + 1);
        end
        check("clip_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("clip_done_cyc", done_q[0], f + 3);

        // Fill that stalls for three cycles when vblank drops after the second pixel.
        wlog.delete();
        done_q.delete();
        start_fill(100, 4, 6, f);
        while (cyc < f + 2) @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        repeat (8) @(negedge clk);
        check("stall_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            check("stall_addr", wlog[i].addr, 100 + i);
            check("stall_cyc", wlog[i].cyc, f + 1 + i + ((i >= 2) ? 3 : 0));
        end
        check("stall_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("stall_done_cyc", done_q[0], f + 8);

        // Fill and push in the same idle cycle: fill first, request afterwards.
        wlog.delete();
        done_q.delete();
        req_valid  = 1'b1;
        req_addr   = ADDR_W'(777);
        req_data   = 4'd2;
        start_fill(50, 2, 4, f);
        req_valid  = 1'b0;
        repeat (12) @(negedge clk);
        check("prio_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("prio_first", wlog[0].addr, 50);
            check("prio_second", wlog[1].addr, 51);
            check("prio_third", wlog[2].addr, 777);
            check("prio_third_data", wlog[2].data, 2);
        end

        // Out-of-range requests: counted, never written, saturating at 255.
        do_reset();
        vblank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(400000, 1, acc, ac);
            check("oob_accepted", 32'(acc), 1);
        end
        repeat (4) @(negedge clk);
        check("oob_drop3", 32'(drop_cnt), 3);
        check("oob_no_write", wlog.size(), 0);
        check("oob_busy", 32'(busy), 0);
        for (int i = 0; i < 300; i++) drive_req(int'($urandom_range(FB_SIZE, ADDR_MAX)), i & 15, acc, ac);
        repeat (2) @(negedge clk);
        check("oob_saturate", 32'(drop_cnt), 255);
        check("oob_no_write2", wlog.size(), 0);

        // Reset in the middle of a fill with entries buffered behind it.
        do_reset();
        vblank = 1'b1;
        start_fill(1000, 50, 5, f);
        drive_req(60, 1, acc, ac);
        drive_req(61, 2, acc, ac);
        while (cyc < f + 6) @(negedge clk);
        check("mid_we_before_rst", 32'(mem_we), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(fill_done), 0);
        @(negedge clk);
        @(negedge clk);
        wlog.delete();
        done_q.delete();
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_no_write_after", wlog.size(), 0);
        check("mid_no_done_after", done_q.size(), 0);
        start_fill(20, 3, 9, f);
        repeat (8) @(negedge clk);
        check("mid_refill_count", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            check("mid_refill_addr", wlog[i].addr, 20 + i);
            check("mid_refill_data", wlog[i].data, 9);
        end
        check("mid_refill_done", done_q.size(), 1);

        // Random requests under random vblank: in-range ones written in order, others dropped.
        do_reset();
        exp_q.delete();
        drops = 0;
        for (int i = 0; i < 400; i++) begin
            vblank    = ($urandom_range(0, 9) < 6);
            req_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 6) == 0) a = int'($urandom_range(FB_SIZE, ADDR_MAX));
            else                           a = int'($urandom_range(0, FB_SIZE - 1));
            d        = int'($urandom_range(0, 15));
            req_addr = ADDR_W'(a);
            req_data = DATA_W'(d);
            if (req_valid && req_ready) begin
                if (a >= FB_SIZE) drops++;
                else              exp_q.push_back('{a, d, 0});
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        vblank    = 1'b1;
        repeat (30) @(negedge clk);
        check("rnd_count", wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            check("rnd_addr", wlog[i].addr, exp_q[i].addr);
            check("rnd_data", wlog[i].data, exp_q[i].data);
        end
        check("rnd_drop_cnt", 32'(drop_cnt), (drops > 255) ? 255 : drops);

        // Random fills (including empty and off-screen ones) with a second start that must be ignored.
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 3))
                0:       base = int'($urandom_range(FB_SIZE - 8, FB_SIZE - 1));
                1:       base = int'($urandom_range(FB_SIZE, ADDR_MAX));
                default: base = int'($urandom_range(0, FB_SIZE - 1));
            endcase
            len = int'($urandom_range(0, 12));
            col = int'($urandom_range(0, 15));
            if (base >= FB_SIZE)         nwr = 0;
            else if (base + len > FB_SIZE) nwr = FB_SIZE - base;
            else                         nwr = len;
            wlog.delete();
            done_q.delete();
            vblank = ($urandom_range(0, 3) != 0);
            start_fill(base, len, col, f);
            if (nwr > 0) begin
                fill_start = 1'b1;
                fill_base  = ADDR_W'(5);
                fill_len   = ADDR_W'(3);
                fill_color = DATA_W'(~col);
                vblank     = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                fill_start = 1'b0;
            end
            for (int k = 0; k < 200 && done_q.size() == 0; k++) begin
                vblank = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            vblank = 1'b1;
            repeat (3) @(negedge clk);
            check("rfill_count", wlog.size(), nwr);
            for (int i = 0; i < nwr && i < wlog.size(); i++) begin
                check("rfill_addr", wlog[i].addr, base + i);
                check("rfill_data", wlog[i].data, col);
            end
            check("rfill_done_count", done_q.size(), 1);
            if (done_q.size() > 0) begin
                if (nwr == 0) check("rfill_done_cyc", done_q[0], f);
                else if (wlog.size() > 0) check("rfill_done_cyc", done_q[0], wlog[wlog.size() - 1].cyc + 1);
            end
        end

        check("writes_only_in_vblank", vb_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, meaning the frame-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 4, meaning the pixel colour width.
REQ-003 SHALL have parameter FB_SIZE, default 307200, meaning the number of valid pixel addresses (640x480).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of 2), meaning the number of pixel-request buffer entries.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port vblank, input, 1 bit: memory writes are permitted only while this is high.
REQ-008 SHALL have port req_valid, input, 1 bit: single-pixel write request.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: pixel address.
REQ-010 SHALL have port req_data, input, DATA_W bits: pixel colour.
REQ-011 SHALL have port req_ready, output, 1 bit: the request buffer can accept an entry.
REQ-012 SHALL have port fill_start, input, 1 bit: one-cycle pulse that starts a block fill.
REQ-013 SHALL have port fill_base, input, ADDR_W bits: first fill address.
REQ-014 SHALL have port fill_len, input, ADDR_W bits: number of pixels to fill.
REQ-015 SHALL have port fill_color, input, DATA_W bits: fill colour.
REQ-016 SHALL have port fill_done, output, 1 bit: one-cycle pulse when a fill ends.
REQ-017 SHALL have port busy, output, 1 bit: high when state is not IDLE or the buffer is non-empty.
REQ-018 SHALL have port mem_we, output, 1 bit: frame-RAM write enable, registered.
REQ-019 SHALL have port mem_addr, output, ADDR_W bits: frame-RAM address, registered.
REQ-020 SHALL have port mem_wdata, output, DATA_W bits: frame-RAM data, registered.
REQ-021 SHALL have port drop_cnt, output, 8 bits: saturating count of rejected out-of-range requests.

Function
REQ-022 SHALL push {req_addr, req_data} into the FIFO on any cycle where req_valid and req_ready are both high.
REQ-023 SHALL drive req_ready = !fifo_full, with no push-through when full, even on a cycle with a simultaneous pop.
REQ-024 SHALL discard, and not push, any accepted request with req_addr >= FB_SIZE; such a request increments drop_cnt, which saturates at 255.
REQ-025 SHALL implement states IDLE, DRAIN and FILL.
REQ-026 SHALL, in IDLE with the FIFO non-empty and vblank high, go to DRAIN.
REQ-027 SHALL, in DRAIN, pop one entry per cycle while vblank is high and the FIFO is non-empty, asserting mem_we with the popped addr/data on the following cycle.
REQ-028 SHALL, in DRAIN, return to IDLE when the FIFO is empty or vblank is low; it SHALL perform no pop on a cycle where vblank is low.
REQ-029 SHALL give a minimum latency, with vblank high, of: request accepted at edge N -> mem_we high in the cycle after edge N+2.
REQ-030 SHALL accept fill_start only in IDLE; a fill_start pulse in any other state SHALL be ignored.
REQ-031 SHALL, on an accepted fill_start, latch fill_base, fill_len and fill_color and enter FILL.
REQ-032 SHALL, in FILL, write one pixel per cycle while vblank is high, at addresses fill_base, fill_base+1, and so on, using a latched down-counter of remaining pixels.
REQ-033 SHALL, in FILL, stall (mem_we low) while vblank is low, resuming at the same address.
REQ-034 SHALL end FILL when the remaining count reaches 0 or the next address would be >= FB_SIZE (clip, no wrap); it SHALL then pulse fill_done for one cycle, in the cycle after the last mem_we, and go to IDLE.
REQ-035 SHALL, for fill_len = 0, perform no write and pulse fill_done in the cycle after acceptance.
REQ-036 SHALL, for fill_base >= FB_SIZE, perform no write and pulse fill_done in the cycle after acceptance.
REQ-037 SHALL continue to accept FIFO pushes during FILL but not pop them until FILL ends.
REQ-038 SHALL, when fill_start and a FIFO push occur in the same IDLE cycle, give the fill priority; the pushed entry drains afterwards.
REQ-039 SHALL drive mem_we low on every cycle with no write.
REQ-040 SHALL hold mem_addr and mem_wdata at their last values whenever mem_we is low.

Reset
REQ-041 SHALL, while rst is low, immediately force state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, fill_done=0, busy=0 and drop_cnt=0; req_ready is 1 once rst goes high.
REQ-042 SHALL, on reset asserted mid-FILL or mid-DRAIN, abandon the pending fill and all buffered entries with no further writes and no fill_done pulse.

Verification
REQ-043 SHALL cover: vblank=1, push (addr 5, data 0xA) -> exactly one write with mem_addr=5, mem_wdata=0xA, 2 cycles after acceptance.
REQ-044 SHALL cover: vblank=0, push 9 requests -> 8 accepted, req_ready=0, no writes; then raise vblank -> 8 writes in consecutive cycles, in push order.
REQ-045 SHALL cover: fill base=307198, len=10, color=3 -> 2 writes (307198, 307199), then fill_done.
REQ-046 SHALL cover: fill base=100, len=4 with vblank dropped for 3 cycles after the 2nd write -> writes to 100..103 with a 3-cycle gap, then one fill_done.
REQ-047 SHALL cover: push req_addr=400000 three times -> drop_cnt=3, no writes; then 300 further out-of-range pushes -> drop_cnt=255.
REQ-048 SHALL cover: assert rst mid-fill -> mem_we=0 immediately, busy=0, no fill_done; a subsequent fill runs normally.
